// File: rtl/render_pkg.sv
// Shared render definitions.
// - vbuf_state_t: vertex-buffer control states.
// - Color index constants used by the render path.
// - Default polygon sizing and a helper that validates a commit's vertex count.
package render_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // back buffer untouched since the last swap/reset
        LOADING = 2'd1,   // at least one vertex written into the back buffer
        PENDING = 2'd2    // committed set waiting for the next vertical blank
    } vbuf_state_t;

    localparam logic [3:0] BLACK   = 4'd0;
    localparam logic [3:0] WHITE   = 4'd1;
    localparam logic [3:0] RED     = 4'd2;
    localparam logic [3:0] GREEN   = 4'd3;
    localparam logic [3:0] BLUE    = 4'd4;
    localparam logic [3:0] YELLOW  = 4'd5;
    localparam logic [3:0] CYAN    = 4'd6;
    localparam logic [3:0] MAGENTA = 4'd7;
    localparam logic [3:0] GRAY    = 4'd8;
    localparam logic [3:0] LBLUE   = 4'd9;

    localparam int DEFAULT_MAX_NUM_VERTICES = 4;
    localparam int DEFAULT_COORD_WIDTH      = 32;

    // Fewer than three vertices cannot describe a fillable polygon.
    localparam int unsigned MIN_POLYGON_VERTICES = 3;

    function automatic logic commit_count_ok(input int unsigned num,
                                             input int unsigned max_num);
        return (num >= MIN_POLYGON_VERTICES) && (num <= max_num);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator.
// Registers a single-cycle pulse one cycle after the raster position
// hcount_in==0 && vcount_in==PIXEL_HEIGHT (start of vertical blank) is sampled.
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   hcount_in       raster x
//   vcount_in       raster y
//   frame_tick_out  one-cycle pulse at the start of vertical blank
module frame_tick_gen #(
    parameter int H_W          = 11,
    parameter int V_W          = 10,
    parameter int PIXEL_HEIGHT = 720
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [H_W-1:0] hcount_in,
    input  logic [V_W-1:0] vcount_in,
    output logic           frame_tick_out
);

    logic tick_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= (hcount_in == '0) && (vcount_in == V_W'(PIXEL_HEIGHT));
        end
    end

    assign frame_tick_out = tick_reg;

endmodule

// File: rtl/polygon_vertex_buffer.sv
// Frame-synchronous double-buffered vertex store feeding draw_polygon.
// Scene logic writes vertices into a back buffer and commits the set; the
// back buffer is copied to the front registers only at the start of vertical
// blank, so the renderer never sees a half-updated polygon.
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   hcount_in, vcount_in  raster position (swap line is vcount_in==PIXEL_HEIGHT)
//   wr_valid_in/ready_out vertex write handshake; write when valid && ready
//   wr_idx_in, wr_x_in, wr_y_in  vertex slot and signed coordinates
//   commit_in, commit_num_in     one-cycle commit pulse and vertex count
//   xs_out, ys_out        front buffer, slot i at [i*COORD_WIDTH +: COORD_WIDTH]
//   num_points_out        front-buffer vertex count
//   valid_out             front buffer holds a committed polygon (sticky)
//   swapped_out           one-cycle pulse on the cycle after a swap
//   error_out             one-cycle pulse for a rejected commit or dropped write
module polygon_vertex_buffer
    import render_pkg::*;
#(
    parameter int PIXEL_WIDTH      = 1280,
    parameter int PIXEL_HEIGHT     = 720,
    parameter int MAX_NUM_VERTICES = DEFAULT_MAX_NUM_VERTICES,
    parameter int COORD_WIDTH      = DEFAULT_COORD_WIDTH
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic [$clog2(PIXEL_WIDTH)-1:0]            hcount_in,
    input  logic [$clog2(PIXEL_HEIGHT)-1:0]           vcount_in,
    input  logic                                      wr_valid_in,
    output logic                                      wr_ready_out,
    input  logic [$clog2(MAX_NUM_VERTICES)-1:0]       wr_idx_in,
    input  logic signed [COORD_WIDTH-1:0]             wr_x_in,
    input  logic signed [COORD_WIDTH-1:0]             wr_y_in,
    input  logic                                      commit_in,
    input  logic [$clog2(MAX_NUM_VERTICES):0]         commit_num_in,
    output logic [MAX_NUM_VERTICES*COORD_WIDTH-1:0]   xs_out,
    output logic [MAX_NUM_VERTICES*COORD_WIDTH-1:0]   ys_out,
    output logic [$clog2(MAX_NUM_VERTICES):0]         num_points_out,
    output logic                                      valid_out,
    output logic                                      swapped_out,
    output logic                                      error_out
);

    localparam int H_W   = $clog2(PIXEL_WIDTH);
    localparam int V_W   = $clog2(PIXEL_HEIGHT);
    localparam int IDX_W = $clog2(MAX_NUM_VERTICES);
    localparam int NUM_W = $clog2(MAX_NUM_VERTICES) + 1;

    vbuf_state_t state_reg, state_next;

    logic frame_tick;
    logic wr_ready;
    logic wr_store;
    logic wr_drop;
    logic commit_accept;
    logic commit_reject;
    logic do_swap;
    logic wr_idx_ok;
    logic commit_num_ok;

    logic signed [COORD_WIDTH-1:0] back_x_reg  [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] back_y_reg  [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] front_x_reg [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] front_y_reg [MAX_NUM_VERTICES];
    logic [NUM_W-1:0]              back_num_reg;
    logic [NUM_W-1:0]              front_num_reg;
    logic                          valid_reg;
    logic                          swapped_reg;
    logic                          error_reg;

    frame_tick_gen #(
        .H_W          (H_W),
        .V_W          (V_W),
        .PIXEL_HEIGHT (PIXEL_HEIGHT)
    ) u_frame_tick_gen (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .frame_tick_out (frame_tick)
    );

    // Only reachable when MAX_NUM_VERTICES is not a power of two.
    assign wr_idx_ok     = (32'(wr_idx_in) < 32'(MAX_NUM_VERTICES));
    assign commit_num_ok = commit_count_ok(32'(commit_num_in), MAX_NUM_VERTICES);

    // ---------------- state register ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (commit_accept) begin
                    state_next = PENDING;
                end else if (wr_store) begin
                    state_next = LOADING;
                end
            end
            LOADING: begin
                if (commit_accept) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    // wr_ready is held low combinationally while rst_in is high so that the
    // reset cycle itself never advertises readiness.
    always_comb begin
        wr_ready      = 1'b0;
        wr_store      = 1'b0;
        wr_drop       = 1'b0;
        commit_accept = 1'b0;
        commit_reject = 1'b0;
        do_swap       = 1'b0;
        case (state_reg)
            IDLE, LOADING: begin
                wr_ready      = !rst_in;
                wr_store      = wr_valid_in && wr_ready && wr_idx_ok;
                wr_drop       = wr_valid_in && wr_ready && !wr_idx_ok;
                commit_accept = commit_in && commit_num_ok;
                commit_reject = commit_in && !commit_num_ok;
            end
            PENDING: begin
                // A tick coinciding with the accepting commit is seen while
                // still in IDLE/LOADING, so that set naturally waits a frame.
                do_swap = frame_tick;
            end
            default: ;
        endcase
    end

    // ---------------- vertex storage ----------------
    // A write and a commit in the same cycle both land at this edge, so the
    // written vertex is part of the committed set.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_NUM_VERTICES; gi++) begin : g_slot
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    back_x_reg[gi]  <= '0;
                    back_y_reg[gi]  <= '0;
                    front_x_reg[gi] <= '0;
                    front_y_reg[gi] <= '0;
                end else begin
                    if (wr_store && (wr_idx_in == IDX_W'(gi))) begin
                        back_x_reg[gi] <= wr_x_in;
                        back_y_reg[gi] <= wr_y_in;
                    end
                    if (do_swap) begin
                        front_x_reg[gi] <= back_x_reg[gi];
                        front_y_reg[gi] <= back_y_reg[gi];
                    end
                end
            end
            assign xs_out[gi*COORD_WIDTH +: COORD_WIDTH] = front_x_reg[gi];
            assign ys_out[gi*COORD_WIDTH +: COORD_WIDTH] = front_y_reg[gi];
        end
    endgenerate

    // ---------------- counts and status pulses ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            back_num_reg  <= '0;
            front_num_reg <= '0;
            valid_reg     <= 1'b0;
            swapped_reg   <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            if (commit_accept) begin
                back_num_reg <= commit_num_in;
            end
            if (do_swap) begin
                front_num_reg <= back_num_reg;
                valid_reg     <= 1'b1;
            end
            swapped_reg <= do_swap;
            error_reg   <= commit_reject || wr_drop;
        end
    end

    assign wr_ready_out   = wr_ready;
    assign num_points_out = front_num_reg;
    assign valid_out      = valid_reg;
    assign swapped_out    = swapped_reg;
    assign error_out      = error_reg;

endmodule
